key_sched: RTL

Multi-key event scheduler for front-panel buttons. It instantiates one `debouncer` per raw key input and latches each debounced press/release edge as a pending request. A round-robin arbiter shares a single output event port among the keys, and one shared hold/repeat counter generates auto-repeat events for the most recently pressed key. It sits between raw panel inputs and the UI/command FSM, which consumes events through a valid/ready handshake.

---
 rtl/key_sched_pkg.sv | 27 ++
 rtl/debouncer.sv | 59 +++++
 rtl/key_sched.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/key_sched_pkg.sv
// key_sched_pkg: shared constants and types for the key scheduler.
//   c_ms()      converts milliseconds to clock cycles at CLK_HZ.
//   ev_kind_e   event kinds carried on the scheduler output port.
//   hold_st_e   states of the hold/auto-repeat FSM.
package key_sched_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  function automatic int unsigned c_ms(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int KIND_W = 2;

  typedef enum logic [KIND_W-1:0] {
    EV_PRESS = 2'd0,
    EV_REL   = 2'd1,
    EV_RPT   = 2'd2
  } ev_kind_e;

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_HOLD = 2'd1,
    H_RPT  = 2'd2
  } hold_st_e;

endpackage

// File: rtl/debouncer.sv
// debouncer: synchronises one raw key level and accepts a new level only
// after it has been stable for CMAX consecutive cycles.
//   clk, rst_n  clock, asynchronous active-low reset
//   a_in        raw, unsynchronised key level (1 = pressed)
//   sig         debounced level
//   pe_sig      one-cycle pulse when sig rises
//   ne_sig      one-cycle pulse when sig falls
module debouncer #(
  parameter int unsigned CMAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_in,
  output logic sig,
  output logic pe_sig,
  output logic ne_sig
);

  localparam int unsigned CW = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CMAX - 1);

  logic          sync1_q, sync2_q;
  logic          sig_q, pe_q, ne_q;
  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sig_q   <= 1'b0;
      pe_q    <= 1'b0;
      ne_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= a_in;
      sync2_q <= sync1_q;
      pe_q    <= 1'b0;
      ne_q    <= 1'b0;
      // Any bounce back to the accepted level restarts the stability count.
      if (sync2_q == sig_q) begin
        cnt_q <= '0;
      end else if (cnt_q == C_LAST) begin
        cnt_q <= '0;
        sig_q <= sync2_q;
        pe_q  <= sync2_q;
        ne_q  <= !sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign sig    = sig_q;
  assign pe_sig = pe_q;
  assign ne_sig = ne_q;

endmodule

// File: rtl/key_sched.sv
// key_sched: multi-key event scheduler for front-panel buttons.
//   clk, rst_n   clock, asynchronous active-low reset
//   a_key        raw key levels, one bit per key (1 = pressed)
//   ev_valid     output event presented
//   ev_key       key index of the event
//   ev_kind      EV_PRESS / EV_REL / EV_RPT
//   ev_ready     consumer accepts when ev_valid && ev_ready
//   key_lvl      debounced key levels
//   ovf          sticky: a press or release edge was lost
// Debounced edges latch as pending requests, a round-robin arbiter shares
// the output register, and one hold counter produces auto-repeat for the
// most recently pressed key at lowest priority.
module key_sched
  import key_sched_pkg::*;
#(
  parameter int          KW        = 2,
  parameter int unsigned DEB_CMAX  = c_ms(5),
  parameter int unsigned HOLD_CMAX = c_ms(500),
  parameter int unsigned RPT_CMAX  = c_ms(100)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2**KW-1:0]   a_key,
  output logic               ev_valid,
  output logic [KW-1:0]      ev_key,
  output logic [KIND_W-1:0]  ev_kind,
  input  logic               ev_ready,
  output logic [2**KW-1:0]   key_lvl,
  output logic               ovf
);

  localparam int          N    = 2**KW;
  localparam int unsigned HMAX = (HOLD_CMAX > RPT_CMAX) ? HOLD_CMAX : RPT_CMAX;
  localparam int unsigned HCW  = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CMAX - 1);
  localparam logic [HCW-1:0] RPT_LAST  = HCW'(RPT_CMAX - 1);

  logic [N-1:0] pe, ne;

  for (genvar i = 0; i < N; i++) begin : g_deb
    debouncer #(.CMAX(DEB_CMAX)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .a_in   (a_key[i]),
      .sig    (key_lvl[i]),
      .pe_sig (pe[i]),
      .ne_sig (ne[i])
    );
  end

  logic [N-1:0]        pp_q, pr_q, pp_d, pr_d, pp_clr, pr_clr;
  logic                prp_q, prp_take, ovf_q, ovf_d;
  logic [KW-1:0]       rr_q;
  logic                ev_valid_q;
  logic [KW-1:0]       ev_key_q;
  logic [KIND_W-1:0]   ev_kind_q;
  logic                load, gnt_vld;
  logic [KW-1:0]       gnt_key, scan;
  hold_st_e            st_q;
  logic [KW-1:0]       hk_q, pe_low;
  logic [HCW-1:0]      hc_q;

  assign load = !ev_valid_q || ev_ready;

  // Round-robin search from rr_q; scanning offsets downwards lets the
  // smallest offset with a request be the last (winning) assignment.
  // NOTE: every always_comb output gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_key = '0;
    scan    = '0;
    for (int j = N - 1; j >= 0; j--) begin
      scan = rr_q + KW'(j);
      if (pp_q[scan] || pr_q[scan]) begin
        gnt_vld = 1'b1;
        gnt_key = scan;
      end
    end
  end

  // Lowest-index press becomes the held key when several fire together.
  always_comb begin
    pe_low = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (pe[j]) pe_low = KW'(j);
    end
  end

  // Pending bookkeeping. A bit granted this cycle frees its slot, so an
  // edge arriving alongside the grant is kept rather than counted as lost.
  always_comb begin
    pp_clr   = '0;
    pr_clr   = '0;
    prp_take = 1'b0;
    if (load) begin
      if (gnt_vld) begin
        if (pp_q[gnt_key]) pp_clr[gnt_key] = 1'b1;
        else               pr_clr[gnt_key] = 1'b1;
      end else begin
        prp_take = prp_q;
      end
    end
    pp_d  = (pp_q & ~pp_clr) | pe;
    pr_d  = (pr_q & ~pr_clr) | ne;
    ovf_d = ovf_q | (|((pe & pp_q & ~pp_clr) | (ne & pr_q & ~pr_clr)));
  end

  // Pending bits, arbiter pointer and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pp_q       <= '0;
      pr_q       <= '0;
      ovf_q      <= 1'b0;
      rr_q       <= '0;
      ev_valid_q <= 1'b0;
      ev_key_q   <= '0;
      ev_kind_q  <= EV_PRESS;
    end else begin
      pp_q  <= pp_d;
      pr_q  <= pr_d;
      ovf_q <= ovf_d;
      if (load) begin
        ev_valid_q <= gnt_vld || prp_q;
        if (gnt_vld) begin
          ev_key_q  <= gnt_key;
          ev_kind_q <= pp_q[gnt_key] ? EV_PRESS : EV_REL;
          rr_q      <= gnt_key + 1'b1;
        end else if (prp_q) begin
          ev_key_q  <= hk_q;
          ev_kind_q <= EV_RPT;
        end
      end
    end
  end

  // Hold/repeat FSM. A repeat firing while prp_q is still set simply keeps
  // it set (coalesced). Retargeting drops an unserved repeat so it can never
  // be reported against the newly held key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= H_IDLE;
      hk_q  <= '0;
      hc_q  <= '0;
      prp_q <= 1'b0;
    end else begin
      if (prp_take) prp_q <= 1'b0;
      case (st_q)
        H_IDLE: begin
          if (|pe) begin
            hk_q <= pe_low;
            hc_q <= '0;
            st_q <= H_HOLD;
          end
        end
        H_HOLD, H_RPT: begin
          if (|pe) begin
            hk_q  <= pe_low;
            hc_q  <= '0;
            st_q  <= H_HOLD;
            prp_q <= 1'b0;
          end else if (ne[hk_q]) begin
            hc_q  <= '0;
            st_q  <= H_IDLE;
            prp_q <= 1'b0;
          end else if (hc_q == ((st_q == H_HOLD) ? HOLD_LAST : RPT_LAST)) begin
            hc_q  <= '0;
            st_q  <= H_RPT;
            prp_q <= 1'b1;
          end else begin
            hc_q <= hc_q + 1'b1;
          end
        end
        default: st_q <= H_IDLE;
      endcase
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_key   = ev_key_q;
  assign ev_kind  = ev_kind_q;
  assign ovf      = ovf_q;

endmodule
